// File: rtl/tessent_data_mux_seq_nch.sv
// rtl/tessent_data_mux_seq_nch.sv - multi-channel functional/IJTAG data mux with blanked switchover
// Each channel runs its own switch sequencer; a shared register snapshots functional data for observation.
module tessent_data_mux_seq_nch #(
   parameter int               WIDTH      = 3,
   parameter int               CHANNELS   = 4,
   parameter int               SETTLE     = 2,
   parameter logic [WIDTH-1:0] SAFE_VALUE = '0
) (
   input  logic                      ijtag_tck,
   input  logic                      ijtag_reset,
   input  logic [CHANNELS-1:0]       ijtag_select,
   input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
   input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
   input  logic                      ijtag_capture_en,
   output logic [CHANNELS*WIDTH-1:0] data_out,
   output logic [CHANNELS-1:0]       ijtag_sel_ack,
   output logic [CHANNELS-1:0]       blanking,
   output logic [CHANNELS*WIDTH-1:0] functional_capture
);

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
   localparam bit         DIRECT     = (SETTLE == 0);

   typedef enum logic [1:0] {
      ST_FUNC        = 2'd0,
      ST_BLANK_TO_IJ = 2'd1,
      ST_IJTAG       = 2'd2,
      ST_BLANK_TO_FN = 2'd3
   } state_t;

   logic [CHANNELS*WIDTH-1:0] r_capture;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [3:0]       r_cnt;
      logic [3:0]       w_cnt_nxt;
      logic [WIDTH-1:0] r_data;
      logic             r_ack;
      logic             r_blank;
      logic             w_sel;

      assign w_sel = ijtag_select[c];

      // A select change while blanking restarts the full interval toward the new target.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         case (r_state)
            ST_FUNC: begin
               if (w_sel) begin
                  if (DIRECT) begin
                     w_state_nxt = ST_IJTAG;
                  end else begin
                     w_state_nxt = ST_BLANK_TO_IJ;
                     w_cnt_nxt   = SETTLE_CNT;
                  end
               end
            end
            ST_BLANK_TO_IJ: begin
               if (!w_sel) begin
                  w_state_nxt = ST_BLANK_TO_FN;
                  w_cnt_nxt   = SETTLE_CNT;
               end else if (r_cnt <= 4'd1) begin
                  w_state_nxt = ST_IJTAG;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
            ST_IJTAG: begin
               if (!w_sel) begin
                  if (DIRECT) begin
                     w_state_nxt = ST_FUNC;
                  end else begin
                     w_state_nxt = ST_BLANK_TO_FN;
                     w_cnt_nxt   = SETTLE_CNT;
                  end
               end
            end
            ST_BLANK_TO_FN: begin
               if (w_sel) begin
                  w_state_nxt = ST_BLANK_TO_IJ;
                  w_cnt_nxt   = SETTLE_CNT;
               end else if (r_cnt <= 4'd1) begin
                  w_state_nxt = ST_FUNC;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
            default: begin
               w_state_nxt = ST_FUNC;
               w_cnt_nxt   = 4'd0;
            end
         endcase
      end

      // Outputs follow the next state so data, ack and blanking all change on the same edge.
      always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
         if (!ijtag_reset) begin
            r_state <= ST_FUNC;
            r_cnt   <= 4'd0;
            r_data  <= SAFE_VALUE;
            r_ack   <= 1'b0;
            r_blank <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= (w_state_nxt == ST_IJTAG);
            r_blank <= (w_state_nxt == ST_BLANK_TO_IJ) || (w_state_nxt == ST_BLANK_TO_FN);
            case (w_state_nxt)
               ST_FUNC:  r_data <= functional_data_in[c*WIDTH +: WIDTH];
               ST_IJTAG: r_data <= ijtag_data_in[c*WIDTH +: WIDTH];
               default:  r_data <= SAFE_VALUE;
            endcase
         end
      end

      assign data_out[c*WIDTH +: WIDTH] = r_data;
      assign ijtag_sel_ack[c]            = r_ack;
      assign blanking[c]                 = r_blank;
   end

   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         r_capture <= '0;
      end else if (ijtag_capture_en) begin
         r_capture <= functional_data_in;
      end
   end

   assign functional_capture = r_capture;

endmodule

// File: tb/tb_tessent_data_mux_seq_nch.sv
// tb/tb_tessent_data_mux_seq_nch.sv - self-checking bench for tessent_data_mux_seq_nch
// Two instances share stimulus: one with SETTLE=2 and one with direct switching (SETTLE=0).
module tb_tessent_data_mux_seq_nch;

   localparam int W    = 3;
   localparam int C    = 4;
   localparam int S    = 2;
   localparam int BUSW = C * W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [C-1:0]    sel;
   logic [BUSW-1:0] fn;
   logic [BUSW-1:0] ij;
   logic            cap;

   logic [BUSW-1:0] dout,  fcap,  dout0, fcap0;
   logic [C-1:0]    ack,   blank, ack0,  blank0;

   int checks = 0;
   int errors = 0;

   // Reference: a channel shows a source only once the last SETTLE+1 sampled selects agree.
   int              run_a [C];
   int              run_b [C];
   logic            last_a[C];
   logic            last_b[C];
   logic [BUSW-1:0] e_dout, e_dout0, e_cap;
   logic [C-1:0]    e_ack, e_blank, e_ack0, e_blank0;

   tessent_data_mux_seq_nch #(.WIDTH(W), .CHANNELS(C), .SETTLE(S), .SAFE_VALUE(3'd0)) dut (
      .ijtag_tck          (clk),
      .ijtag_reset        (rst_n),
      .ijtag_select       (sel),
      .functional_data_in (fn),
      .ijtag_data_in      (ij),
      .ijtag_capture_en   (cap),
      .data_out           (dout),
      .ijtag_sel_ack      (ack),
      .blanking           (blank),
      .functional_capture (fcap)
   );

   tessent_data_mux_seq_nch #(.WIDTH(W), .CHANNELS(C), .SETTLE(0), .SAFE_VALUE(3'd0)) dut0 (
      .ijtag_tck          (clk),
      .ijtag_reset        (rst_n),
      .ijtag_select       (sel),
      .functional_data_in (fn),
      .ijtag_data_in      (ij),
      .ijtag_capture_en   (cap),
      .data_out           (dout0),
      .ijtag_sel_ack      (ack0),
      .blanking           (blank0),
      .functional_capture (fcap0)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < C; c++) begin
         run_a[c]  = 16;
         run_b[c]  = 16;
         last_a[c] = 1'b0;
         last_b[c] = 1'b0;
      end
      e_dout = '0; e_dout0 = '0; e_cap = '0;
      e_ack = '0; e_blank = '0; e_ack0 = '0; e_blank0 = '0;
   endtask

   task automatic model_edge();
      for (int c = 0; c < C; c++) begin
         if (sel[c] == last_a[c]) begin
            if (run_a[c] < 16) run_a[c]++;
         end else begin
            last_a[c] = sel[c];
            run_a[c]  = 1;
         end
         if (sel[c] == last_b[c]) begin
            if (run_b[c] < 16) run_b[c]++;
         end else begin
            last_b[c] = sel[c];
            run_b[c]  = 1;
         end
         if (run_a[c] >= S + 1) begin
            e_dout[c*W +: W] = sel[c] ? ij[c*W +: W] : fn[c*W +: W];
            e_ack[c]   = sel[c];
            e_blank[c] = 1'b0;
         end else begin
            e_dout[c*W +: W] = 3'd0;
            e_ack[c]   = 1'b0;
            e_blank[c] = 1'b1;
         end
         if (run_b[c] >= 1) begin
            e_dout0[c*W +: W] = sel[c] ? ij[c*W +: W] : fn[c*W +: W];
            e_ack0[c]   = sel[c];
            e_blank0[c] = 1'b0;
         end else begin
            e_dout0[c*W +: W] = 3'd0;
            e_ack0[c]   = 1'b0;
            e_blank0[c] = 1'b1;
         end
      end
      if (cap) e_cap = fn;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sel   = '0;
      fn    = 12'hABC;
      ij    = BUSW'($urandom);
      cap   = 1'b0;
      #2;
      checks++;
      if (dout !== 12'h000 || ack !== 4'h0 || blank !== 4'h0 || fcap !== 12'h000 || dout0 !== 12'h000) begin
         errors++;
         $display("FAIL reset_async dout=%h ack=%b blank=%b cap=%h dout0=%h required all zero", dout, ack, blank, fcap, dout0);
      end
      @(posedge clk); #1;
      checks++;
      if (dout !== 12'h000 || ack !== 4'h0 || blank !== 4'h0) begin
         errors++;
         $display("FAIL reset_held dout=%h ack=%b blank=%b required zero", dout, ack, blank);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      tick();
      checks++;
      if (dout !== 12'hABC || ack !== 4'h0 || blank !== 4'h0 || dout0 !== 12'hABC) begin
         errors++;
         $display("FAIL reset_first_func dout=%h dout0=%h ack=%b blank=%b required abc abc 0 0", dout, dout0, ack, blank);
      end
   endtask

   task automatic test_switch();
      sel = '0;
      tick();
      sel[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fn = BUSW'($urandom); ij = BUSW'($urandom);
         fn[1*W +: W] = 3'd2;
         ij[1*W +: W] = 3'd5;
         tick();
         checks++;
         if (dout[1*W +: W] !== ((k < 2) ? 3'd0 : 3'd5) || blank[1] !== (k < 2) || ack[1] !== (k >= 2)) begin
            errors++;
            $display("FAIL switch_ch1 k=%0d data=%0d blank=%b ack=%b", k, dout[1*W +: W], blank[1], ack[1]);
         end
         checks++;
         if (dout !== e_dout || ack !== e_ack || blank !== e_blank || dout0 !== e_dout0 || ack0 !== e_ack0 || blank0 !== e_blank0) begin
            errors++;
            $display("FAIL switch_model k=%0d dout=%h/%h ack=%b/%b blank=%b/%b dout0=%h/%h", k, dout, e_dout, ack, e_ack, blank, e_blank, dout0, e_dout0);
         end
      end
   endtask

   task automatic test_abort();
      sel = '0;
      fn[1*W +: W] = 3'd2;
      ij[1*W +: W] = 3'd5;
      repeat (4) tick();
      sel[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         sel[1] = 1'b0;
         checks++;
         if (dout[1*W +: W] !== ((k < 3) ? 3'd0 : 3'd2) || ack[1] !== 1'b0 || blank[1] !== (k < 3)) begin
            errors++;
            $display("FAIL abort_ch1 k=%0d data=%0d ack=%b blank=%b", k, dout[1*W +: W], ack[1], blank[1]);
         end
         checks++;
         if (dout !== e_dout || ack !== e_ack || blank !== e_blank || dout0 !== e_dout0 || blank0 !== e_blank0) begin
            errors++;
            $display("FAIL abort_model k=%0d dout=%h/%h ack=%b/%b blank=%b/%b", k, dout, e_dout, ack, e_ack, blank, e_blank);
         end
      end
   endtask

   task automatic test_all_switch();
      sel = 4'hF;
      for (int k = 0; k < 9; k++) begin
         fn = BUSW'($urandom); ij = BUSW'($urandom);
         if (k == 5) sel[3] = 1'b0;
         tick();
         checks++;
         if (dout !== e_dout || ack !== e_ack || blank !== e_blank || dout0 !== e_dout0 || ack0 !== e_ack0 || blank0 !== e_blank0) begin
            errors++;
            $display("FAIL all_switch k=%0d dout=%h/%h ack=%b/%b blank=%b/%b", k, dout, e_dout, ack, e_ack, blank, e_blank);
         end
      end
      checks++;
      if (ack !== 4'b0111 || blank !== 4'b0000 || dout[3*W +: W] !== fn[3*W +: W]) begin
         errors++;
         $display("FAIL all_switch_end ack=%b blank=%b ch3=%0d required 0111 0000 %0d", ack, blank, dout[3*W +: W], fn[3*W +: W]);
      end
   endtask

   task automatic test_capture();
      sel = '0;
      repeat (4) tick();
      sel[0] = 1'b1;
      fn  = 12'h5A3;
      cap = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         cap = 1'b0;
         fn  = 12'h000;
         checks++;
         if (fcap !== 12'h5A3 || fcap0 !== 12'h5A3) begin
            errors++;
            $display("FAIL capture k=%0d cap=%h cap0=%h required 5a3", k, fcap, fcap0);
         end
         checks++;
         if (dout !== e_dout || ack !== e_ack || blank !== e_blank || fcap !== e_cap || blank[0] !== (k < 2)) begin
            errors++;
            $display("FAIL capture_switch k=%0d dout=%h/%h ack=%b/%b blank=%b/%b", k, dout, e_dout, ack, e_ack, blank, e_blank);
         end
      end
   endtask

   task automatic test_reset_mid_blank();
      sel = '0;
      repeat (4) tick();
      sel[2] = 1'b1;
      tick();
      checks++;
      if (blank[2] !== 1'b1 || ack0[2] !== 1'b1 || blank0 !== 4'h0) begin
         errors++;
         $display("FAIL mid_blank_pre blank=%b ack0=%b blank0=%b", blank, ack0, blank0);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dout !== 12'h000 || ack !== 4'h0 || blank !== 4'h0 || fcap !== 12'h000 || dout0 !== 12'h000 || ack0 !== 4'h0) begin
         errors++;
         $display("FAIL mid_blank_reset dout=%h ack=%b blank=%b cap=%h dout0=%h ack0=%b", dout, ack, blank, fcap, dout0, ack0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fn = BUSW'($urandom); ij = BUSW'($urandom);
         tick();
         checks++;
         if (dout !== e_dout || ack !== e_ack || blank !== e_blank || dout0 !== e_dout0 || ack0 !== e_ack0 || blank0 !== 4'h0) begin
            errors++;
            $display("FAIL mid_blank_after k=%0d dout=%h/%h blank=%b/%b dout0=%h/%h blank0=%b", k, dout, e_dout, blank, e_blank, dout0, e_dout0, blank0);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < C; c++)
            if ($urandom_range(0, 3) == 0) sel[c] = ~sel[c];
         fn  = BUSW'($urandom);
         ij  = BUSW'($urandom);
         cap = ($urandom_range(0, 4) == 0);
         tick();
         checks++;
         if (dout !== e_dout || ack !== e_ack || blank !== e_blank || fcap !== e_cap) begin
            errors++;
            $display("FAIL random_a k=%0d dout=%h/%h ack=%b/%b blank=%b/%b cap=%h/%h", k, dout, e_dout, ack, e_ack, blank, e_blank, fcap, e_cap);
         end
         checks++;
         if (dout0 !== e_dout0 || ack0 !== e_ack0 || blank0 !== e_blank0 || fcap0 !== e_cap) begin
            errors++;
            $display("FAIL random_b k=%0d dout0=%h/%h ack0=%b/%b blank0=%b/%b", k, dout0, e_dout0, ack0, e_ack0, blank0, e_blank0);
         end
      end
      cap = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_switch();
      test_abort();
      test_all_switch();
      test_capture();
      test_reset_mid_blank();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
